// File: rtl/leaf_pkt_pkg.sv
// Shared packet geometry for the leaf output path: field widths, offsets,
// the idle packet constant and a packing helper.
package leaf_pkt_pkg;

  localparam int PAYLOAD_W = 32;
  localparam int LEAF_W    = 5;
  localparam int PORT_W    = 4;
  localparam int ADDR_W    = 7;
  localparam int PKT_W     = 1 + LEAF_W + PORT_W + ADDR_W + PAYLOAD_W;

  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_W;
  localparam int PORT_LSB    = ADDR_LSB + ADDR_W;
  localparam int LEAF_LSB    = PORT_LSB + PORT_W;
  localparam int VALID_BIT   = LEAF_LSB + LEAF_W;

  typedef logic [PKT_W-1:0] packet_t;

  localparam packet_t IDLE_PACKET = '0;

  function automatic packet_t pack_packet(
    input logic                 valid,
    input logic [LEAF_W-1:0]    leaf,
    input logic [PORT_W-1:0]    port,
    input logic [ADDR_W-1:0]    addr,
    input logic [PAYLOAD_W-1:0] payload
  );
    return {valid, leaf, port, addr, payload};
  endfunction

endpackage

// File: rtl/leaf_port_fifo.sv
// Synchronous per-port FIFO; push is ignored when full, pop ignored when empty.
module leaf_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Credit-gated round-robin packet builder: buffers each user stream, stamps
// destination and wrapping address, and drives one registered BFT packet per cycle.
module leaf_stream_packetizer
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS   = PKT_W,
  parameter int PAYLOAD_BITS  = PAYLOAD_W,
  parameter int NUM_LEAF_BITS = LEAF_W,
  parameter int NUM_PORT_BITS = PORT_W,
  parameter int NUM_ADDR_BITS = ADDR_W,
  parameter int NUM_OUT_PORTS = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int CREDIT_BITS   = 8,
  parameter int INIT_CREDITS  = 64
) (
  input  logic                                                clk_bft,
  input  logic                                                reset,
  input  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0]               din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                            vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                            ack_interface2user,
  input  logic [(NUM_LEAF_BITS+NUM_PORT_BITS)*NUM_OUT_PORTS-1:0] dest_cfg,
  input  logic                                                credit_vld,
  input  logic [((NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1)-1:0] credit_port,
  input  logic [CREDIT_BITS-1:0]                              credit_amt,
  input  logic                                                resend,
  output logic [PACKET_BITS-1:0]                              dout_leaf_interface2bft
);

  localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int PTR_W     = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_OUT_PORTS - 1);

  logic [NUM_OUT_PORTS-1:0] full;
  logic [NUM_OUT_PORTS-1:0] empty;
  logic [NUM_OUT_PORTS-1:0] push;
  logic [NUM_OUT_PORTS-1:0] pop;
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [PAYLOAD_BITS-1:0]  fifo_dout   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_cnt    [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit      [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_next [NUM_OUT_PORTS];
  logic [CREDIT_BITS:0]     credit_sum  [NUM_OUT_PORTS];

  logic [PTR_W-1:0]         rr;
  logic [PTR_W-1:0]         rr_next;
  logic [PTR_W-1:0]         scan;
  logic [PTR_W-1:0]         grant_idx;
  logic                     grant_vld;
  logic [DEST_BITS-1:0]     sel_dest;
  logic [NUM_ADDR_BITS-1:0] sel_addr;
  logic [PAYLOAD_BITS-1:0]  sel_word;

  assign ack_interface2user = ~full & {NUM_OUT_PORTS{~reset}};

  for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
    logic ret;

    assign push[gi]     = vld_user2interface[gi] & ack_interface2user[gi];
    assign eligible[gi] = ~empty[gi] & (credit[gi] != '0);
    assign pop[gi]      = grant_vld & (grant_idx == PTR_W'(gi));
    assign ret          = credit_vld & (32'(credit_port) == gi);

    // One extra bit catches overflow of (credit + amt - 1); eligibility
    // guarantees credit >= 1 whenever pop is set, so no underflow.
    assign credit_sum[gi]  = {1'b0, credit[gi]}
                           + (ret ? {1'b0, credit_amt} : '0)
                           - (CREDIT_BITS+1)'(pop[gi]);
    assign credit_next[gi] = credit_sum[gi][CREDIT_BITS] ? '1
                                                         : credit_sum[gi][CREDIT_BITS-1:0];

    leaf_port_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk_bft),
      .rst   (reset),
      .push  (push[gi]),
      .pop   (pop[gi]),
      .din   (din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full  (full[gi]),
      .empty (empty[gi]),
      .dout  (fifo_dout[gi])
    );
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      scan = PTR_W'((32'(rr) + k) % NUM_OUT_PORTS);
      if (!grant_vld && !resend && eligible[scan]) begin
        grant_vld = 1'b1;
        grant_idx = scan;
      end
    end
  end

  assign rr_next = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_dest = '0;
    sel_addr = '0;
    sel_word = '0;
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        sel_dest = dest_cfg[k*DEST_BITS +: DEST_BITS];
        sel_addr = addr_cnt[k];
        sel_word = fifo_dout[k];
      end
    end
  end

  always_ff @(posedge clk_bft or posedge reset) begin
    if (reset) begin
      rr                      <= '0;
      dout_leaf_interface2bft <= '0;
      for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
        addr_cnt[k] <= '0;
        credit[k]   <= CREDIT_BITS'(INIT_CREDITS);
      end
    end else begin
      if (grant_vld) begin
        dout_leaf_interface2bft <= {1'b1, sel_dest, sel_addr, sel_word};
        addr_cnt[grant_idx]     <= addr_cnt[grant_idx] + 1'b1;
        rr                      <= rr_next;
      end else if (!resend) begin
        dout_leaf_interface2bft <= '0;
      end
      for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
        credit[k] <= credit_next[k];
      end
    end
  end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Bench for leaf_stream_packetizer: directed scenarios plus random traffic,
// each cycle compared against a queue-based reference model.
module tb_leaf_stream_packetizer;
  import leaf_pkt_pkg::*;

  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int INIT_CR = 2;
  localparam int CMAX    = 255;

  logic             clk_bft = 1'b0;
  logic             reset   = 1'b0;
  logic [32*N-1:0]  din     = '0;
  logic [N-1:0]     vld     = '0;
  logic [N-1:0]     ack;
  logic [9*N-1:0]   dest_cfg;
  logic             credit_vld  = 1'b0;
  logic [1:0]       credit_port = '0;
  logic [7:0]       credit_amt  = '0;
  logic             resend      = 1'b0;
  logic [48:0]      dout;

  always #5 clk_bft = ~clk_bft;

  leaf_stream_packetizer #(
    .NUM_OUT_PORTS (N),
    .FIFO_DEPTH    (DEPTH),
    .INIT_CREDITS  (INIT_CR)
  ) dut (
    .clk_bft                 (clk_bft),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dest_cfg                (dest_cfg),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .credit_amt              (credit_amt),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout)
  );

  // Reference model state
  logic [31:0] mq [N][$];
  int          mcredit [N];
  int          maddr   [N];
  int          mrr;
  logic [48:0] mdout;
  logic [8:0]  dest [N];

  int errors = 0;
  int checks = 0;

  logic        pin_en   = 1'b0;
  int          pin_port = 0;
  logic [31:0] pin_word = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      mcredit[i] = INIT_CR;
      maddr[i]   = 0;
    end
    mrr   = 0;
    mdout = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] room;
    int           g;
    logic [31:0]  w;
    for (int i = 0; i < N; i++) room[i] = (mq[i].size() < DEPTH);
    if (!resend) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && mq[(mrr + k) % N].size() > 0 && mcredit[(mrr + k) % N] > 0)
          g = (mrr + k) % N;
      end
      if (g >= 0) begin
        w     = mq[g].pop_front();
        mdout = pack_packet(1'b1, dest[g][8:4], dest[g][3:0], 7'(maddr[g]), w);
        maddr[g]   = (maddr[g] + 1) % 128;
        mcredit[g] = mcredit[g] - 1;
        mrr        = (g + 1) % N;
      end else begin
        mdout = '0;
      end
    end
    if (credit_vld && int'(credit_port) < N) begin
      mcredit[credit_port] = mcredit[credit_port] + int'(credit_amt);
      if (mcredit[credit_port] > CMAX) mcredit[credit_port] = CMAX;
    end
    for (int i = 0; i < N; i++)
      if (vld[i] && room[i]) mq[i].push_back(din[i*32 +: 32]);
  endtask

  task automatic compare();
    logic [N-1:0] eack;
    for (int i = 0; i < N; i++) eack[i] = (mq[i].size() < DEPTH) && !reset;
    check("dout", 64'(dout), 64'(mdout));
    check("ack", 64'(ack), 64'(eack));
  endtask

  task automatic step(input logic [N-1:0] v, input logic rs, input logic cv,
                      input int cp, input int amt);
    vld         = v;
    resend      = rs;
    credit_vld  = cv;
    credit_port = 2'(cp);
    credit_amt  = 8'(amt);
    for (int i = 0; i < N; i++) din[i*32 +: 32] = $urandom;
    if (pin_en) din[pin_port*32 +: 32] = pin_word;
    @(posedge clk_bft);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) dest[i] = 9'($urandom);
    dest[2] = {5'd3, 4'd9};
    for (int i = 0; i < N; i++) dest_cfg[i*9 +: 9] = dest[i];

    // Reset state
    #1 reset = 1'b1;
    #1 check("ack_in_reset", 64'(ack), 64'(0));
    repeat (2) @(posedge clk_bft);
    #1 check("dout_in_reset", 64'(dout), 64'(0));
    reset = 1'b0;
    model_reset();
    #1 compare();

    // Single word on port 2
    pin_en = 1'b1; pin_port = 2; pin_word = 32'hDEADBEEF;
    step(4'b0100, 1'b0, 1'b0, 0, 0);
    pin_en = 1'b0;
    step('0, 1'b0, 1'b0, 0, 0);
    check("single_pkt", 64'(dout),
          64'(pack_packet(1'b1, 5'd3, 4'd9, 7'd0, 32'hDEADBEEF)));
    step('0, 1'b0, 1'b0, 0, 0);
    check("single_idle", 64'(dout), 64'(0));

    // Credit exhaustion on port 0, then return of 3
    for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, 1'b0, 0, 0);
    idle(4);
    step('0, 1'b0, 1'b1, 0, 3);
    idle(5);
    // Simultaneous decrement and return
    for (int i = 0; i < 8; i++) step(4'b0001, 1'b0, 1'b1, 0, 1);
    for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0, 0, 0);
    idle(4);

    // Saturation on port 3
    step('0, 1'b0, 1'b1, 3, 255);
    step('0, 1'b0, 1'b1, 3, 200);
    for (int i = 0; i < 262; i++) step(4'b1000, 1'b0, 1'b0, 0, 0);
    idle(4);
    step('0, 1'b0, 1'b1, 3, 10);
    idle(6);

    // Round-robin with all ports backlogged and resend pulses
    for (int p = 0; p < N; p++) step(4'hF, 1'b0, 1'b1, p, 100);
    for (int i = 0; i < 30; i++)
      step(4'hF, (i == 10 || i == 11 || i == 20), 1'b1, i % N, 1);
    idle(12);

    // Resend hold while port 1 streams
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1'b0, 0, 0);
    idle(6);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic cv;
      int   amt;
      cv  = ($urandom_range(0, 2) == 0);
      amt = ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 7);
      step(N'($urandom), ($urandom_range(0, 7) == 0), cv, $urandom_range(0, N-1), amt);
    end

    // Asynchronous reset with FIFOs partly filled and a packet on dout
    for (int p = 0; p < N; p++) step('0, 1'b0, 1'b1, p, 50);
    step(4'hF, 1'b0, 1'b0, 0, 0);
    step(4'hF, 1'b0, 1'b0, 0, 0);
    step(4'hF, 1'b1, 1'b0, 0, 0);
    step(4'hF, 1'b1, 1'b0, 0, 0);
    #3 reset = 1'b1;
    vld = '0; resend = 1'b0;
    #1 check("dout_async_rst", 64'(dout), 64'(0));
    check("ack_async_rst", 64'(ack), 64'(0));
    @(posedge clk_bft);
    #1 check("dout_held_rst", 64'(dout), 64'(0));
    reset = 1'b0;
    model_reset();
    #1 check("ack_after_rst", 64'(ack), 64'hF);
    idle(5);

    // Address wrap on port 0: 130 words with credits topped up each cycle
    for (int i = 0; i < 130; i++) step(4'b0001, 1'b0, 1'b1, 0, 1);
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
